spi_master_arbiter: RTL
=======================

Name: spi_master_arbiter

Overview:
- Shares one spi_master instance among NUM_REQ independent requesters.
- Arbitrates round-robin and applies the winner's SPI mode (CPOL/CPHA), inserting a settle gap when the mode changes.
- Drives go/datai, tracks busy to completion, and returns the received word with a per-requester ack pulse.
- Sits between system-side clients and spi_master; the spi_master ports connect directly to the m_* ports.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_WIDTH, 8, SPI word width, matches spi_master.
- CLK_DIVIDER_WIDTH, 4, width of the spi_master clock divider.
- SETTLE_CYCLES, 4, idle cycles inserted after a CPOL/CPHA change before go (>=1).
- TIMEOUT, 64, cycles allowed for m_busy to rise after go before the request is failed.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- resetb  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  request per client; held high until the matching ack.
- req_data  in  NUM_REQ*DATA_WIDTH  tx word per client, slice i = client i.
- req_cpol  in  NUM_REQ  CPOL per client.
- req_cpha  in  NUM_REQ  CPHA per client.
- cfg_clk_divider  in  CLK_DIVIDER_WIDTH  divider, sampled at grant.
- ack  out  NUM_REQ  one-cycle completion pulse to the granted client.
- rsp_data  out  DATA_WIDTH  received word, valid while ack is high and held until the next completion.
- rsp_err  out  1  high with ack on timeout.
- active  out  1  high from grant through the ack cycle.
- m_go  out  1  start pulse to spi_master.
- m_datai  out  DATA_WIDTH  tx word, stable for the whole transaction.
- m_cpol  out  1  CPOL to spi_master and slave.
- m_cpha  out  1  CPHA to spi_master and slave.
- m_clk_divider  out  CLK_DIVIDER_WIDTH  divider to spi_master.
- m_busy  in  1  spi_master busy.
- m_datao  in  DATA_WIDTH  spi_master received word.

Behaviour:
- Reset values: every output is 0. The round-robin pointer is NUM_REQ-1, so client 0 wins first. State is IDLE. The asynchronous assert immediately forces m_go low and aborts any transaction with no ack.
- IDLE: if any req bit is set, grant the first set bit scanning from pointer+1 with wrap-around.
  - In the same edge, latch the index, m_datai, m_clk_divider and the new mode, and set active.
  - If the new mode differs from the current m_cpol/m_cpha, update the mode outputs and go to SETTLE. Otherwise go to LAUNCH.
- SETTLE: count SETTLE_CYCLES cycles with m_go low, then go to LAUNCH.
- LAUNCH: m_go=1 for exactly this one cycle, then go to WAIT_BUSY with the timeout counter cleared.
  - With an unchanged mode, m_go is high on the 2nd cycle after req is first seen in IDLE.
- WAIT_BUSY: go to WAIT_END on m_busy=1.
  - On the TIMEOUT-th cycle without busy, go to RESP with rsp_err=1 and rsp_data=0.
- WAIT_END: on the first cycle with m_busy=0, capture m_datao into rsp_data, clear rsp_err, and go to RESP.
- RESP: pulse ack[index]=1 for one cycle and set pointer=index. Return to IDLE and clear active.
  - The client must drop req in the cycle after ack, or it re-enters arbitration.
- No pipelining: at most one transaction is outstanding, and IDLE lasts at least 1 cycle between transactions.
- Boundary conditions:
  - A req dropped mid-transaction is ignored; the transfer completes and ack still pulses.
  - req_data and req_cpol/req_cpha changing after grant have no effect.
  - m_busy already high in IDLE is ignored.
  - All req bits set simultaneously: strict rotation 0,1,2,0…
  - ack is one-hot or zero.

Test Plan:
1. Single transfer: req[0]=1, data 0xA5, mode 0, slave tx 0x11, divider 4.
   - Required: m_go pulses once.
   - Required: ack[0] with rsp_data=0x11 and rsp_err=0.
   - Required: the slave receives 0xA5.
2. Fairness: hold req=3'b111 continuously.
   - Required: acks in order 0,1,2,0,1,2.
   - Required: m_go is never asserted while active is high from an earlier grant.
3. Mode change: client 0 in mode 0, then client 1 with CPOL=1, CPHA=1.
   - Required: m_cpol and m_cpha go to 1, followed by exactly 4 cycles with m_go low, then m_go.
   - Required: loop across all 4 modes with slave words 0x11/0x22/0x33/0x44 returned correctly.
4. Same mode back-to-back: 2 mode-0 requests.
   - Required: no SETTLE; m_go is exactly 2 cycles after req is seen.
5. Timeout: stubbed master with m_busy stuck 0.
   - Required: one m_go pulse.
   - Required: ack after 64 cycles with rsp_err=1 and rsp_data=0.
   - Required: the next request is still served.
6. Reset mid-transfer: assert resetb low during WAIT_END.
   - Required: all outputs 0 asynchronously and no ack.
   - Required: after release, req[2] is served correctly with client 0 still having first priority.

Source files
------------

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter that shares one spi_master among NUM_REQ clients.
// It applies the winning client's SPI mode, settles after a mode change, launches the transfer and returns the result.
module spi_master_arbiter #(
    parameter int NUM_REQ           = 3,
    parameter int DATA_WIDTH        = 8,
    parameter int CLK_DIVIDER_WIDTH = 4,
    parameter int SETTLE_CYCLES     = 4,
    parameter int TIMEOUT           = 64
) (
    input  logic                            clk,
    input  logic                            resetb,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_cpol,
    input  logic [NUM_REQ-1:0]              req_cpha,
    input  logic [CLK_DIVIDER_WIDTH-1:0]    cfg_clk_divider,
    output logic [NUM_REQ-1:0]              ack,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            rsp_err,
    output logic                            active,
    output logic                            m_go,
    output logic [DATA_WIDTH-1:0]           m_datai,
    output logic                            m_cpol,
    output logic                            m_cpha,
    output logic [CLK_DIVIDER_WIDTH-1:0]    m_clk_divider,
    input  logic                            m_busy,
    input  logic [DATA_WIDTH-1:0]           m_datao
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int MAX_C  = (SETTLE_CYCLES > TIMEOUT) ? SETTLE_CYCLES : TIMEOUT;
    localparam int CNT_W  = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETTLE    = 3'd1,
        S_LAUNCH    = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_END  = 3'd4,
        S_RESP      = 3'd5
    } state_t;

    state_t                         r_state,  w_state_nxt;
    logic [IDX_W-1:0]               r_ptr,    w_ptr_nxt;
    logic [IDX_W-1:0]               r_idx,    w_idx_nxt;
    logic [CNT_W-1:0]               r_cnt,    w_cnt_nxt;
    logic [NUM_REQ-1:0]             r_ack,    w_ack_nxt;
    logic [DATA_WIDTH-1:0]          r_rsp_data, w_rsp_data_nxt;
    logic                           r_rsp_err, w_rsp_err_nxt;
    logic                           r_active, w_active_nxt;
    logic                           r_go,     w_go_nxt;
    logic [DATA_WIDTH-1:0]          r_datai,  w_datai_nxt;
    logic                           r_cpol,   w_cpol_nxt;
    logic                           r_cpha,   w_cpha_nxt;
    logic [CLK_DIVIDER_WIDTH-1:0]   r_div,    w_div_nxt;

    logic                           w_pick_found;
    logic [IDX_W-1:0]               w_pick_idx;
    logic [NUM_REQ-1:0]             w_idx_onehot;

    // First requester after the pointer, wrapping; returns {found, index}.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req_v,
                                               input logic [IDX_W-1:0]   ptr);
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        idx   = {IDX_W{1'b0}};
        cand  = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (cand == IDX_W'(NUM_REQ - 1)) begin
                cand = {IDX_W{1'b0}};
            end else begin
                cand = cand + IDX_W'(1);
            end
            if (!found && req_v[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    assign {w_pick_found, w_pick_idx} = rr_pick(req, r_ptr);
    assign w_idx_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_idx;

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_idx_nxt      = r_idx;
        w_cnt_nxt      = r_cnt;
        w_ack_nxt      = {NUM_REQ{1'b0}};
        w_rsp_data_nxt = r_rsp_data;
        w_rsp_err_nxt  = r_rsp_err;
        w_active_nxt   = r_active;
        w_go_nxt       = 1'b0;
        w_datai_nxt    = r_datai;
        w_cpol_nxt     = r_cpol;
        w_cpha_nxt     = r_cpha;
        w_div_nxt      = r_div;
        case (r_state)
            S_IDLE: begin
                if (w_pick_found) begin
                    w_idx_nxt    = w_pick_idx;
                    w_datai_nxt  = req_data[w_pick_idx*DATA_WIDTH +: DATA_WIDTH];
                    w_div_nxt    = cfg_clk_divider;
                    w_active_nxt = 1'b1;
                    w_cnt_nxt    = {CNT_W{1'b0}};
                    if ({req_cpol[w_pick_idx], req_cpha[w_pick_idx]} != {r_cpol, r_cpha}) begin
                        w_cpol_nxt  = req_cpol[w_pick_idx];
                        w_cpha_nxt  = req_cpha[w_pick_idx];
                        w_state_nxt = S_SETTLE;
                    end else begin
                        w_go_nxt    = 1'b1;
                        w_state_nxt = S_LAUNCH;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    w_go_nxt    = 1'b1;
                    w_state_nxt = S_LAUNCH;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            S_LAUNCH: begin
                w_cnt_nxt   = {CNT_W{1'b0}};
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (m_busy) begin
                    w_state_nxt = S_WAIT_END;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    // Master never started: fail the request back to its client.
                    w_ack_nxt      = w_idx_onehot;
                    w_rsp_err_nxt  = 1'b1;
                    w_rsp_data_nxt = {DATA_WIDTH{1'b0}};
                    w_state_nxt    = S_RESP;
                end else begin
                    w_cnt_nxt      = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT_END: begin
                if (!m_busy) begin
                    w_ack_nxt      = w_idx_onehot;
                    w_rsp_err_nxt  = 1'b0;
                    w_rsp_data_nxt = m_datao;
                    w_state_nxt    = S_RESP;
                end else begin
                    w_state_nxt    = S_WAIT_END;
                end
            end
            S_RESP: begin
                w_ptr_nxt    = r_idx;
                w_active_nxt = 1'b0;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_active_nxt = 1'b0;
                w_state_nxt  = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer without an ack.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state    <= S_IDLE;
            r_ptr      <= IDX_W'(NUM_REQ - 1);
            r_idx      <= {IDX_W{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_ack      <= {NUM_REQ{1'b0}};
            r_rsp_data <= {DATA_WIDTH{1'b0}};
            r_rsp_err  <= 1'b0;
            r_active   <= 1'b0;
            r_go       <= 1'b0;
            r_datai    <= {DATA_WIDTH{1'b0}};
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_div      <= {CLK_DIVIDER_WIDTH{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_idx      <= w_idx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ack      <= w_ack_nxt;
            r_rsp_data <= w_rsp_data_nxt;
            r_rsp_err  <= w_rsp_err_nxt;
            r_active   <= w_active_nxt;
            r_go       <= w_go_nxt;
            r_datai    <= w_datai_nxt;
            r_cpol     <= w_cpol_nxt;
            r_cpha     <= w_cpha_nxt;
            r_div      <= w_div_nxt;
        end
    end

    assign ack           = r_ack;
    assign rsp_data      = r_rsp_data;
    assign rsp_err       = r_rsp_err;
    assign active        = r_active;
    assign m_go          = r_go;
    assign m_datai       = r_datai;
    assign m_cpol        = r_cpol;
    assign m_cpha        = r_cpha;
    assign m_clk_divider = r_div;

endmodule
